// File: rtl/robo_navegador_param.sv
// -----------------------------------------------------------------------------
// robo_navegador_param
//
// Pipe-map navigation controller using a left-hand wall-following rule.
// Debris in front of the robot is removed internally: `recolher_entulho` is
// held for a class-dependent number of cycles (REM_LEVE/REM_MEDIO/REM_PESADO)
// and then the decision logic resumes. Decisions fire every cycle in
// continuous mode, or only on a `step` pulse in step mode.
//
// Optional feature macro: ROBO_WATCHDOG_EN
//   defined   : counts consecutive left turns with no advance or removal in
//               between; WDOG_GIROS of them send the FSM to ERRO and raise
//               the sticky `anomalia` flag.
//   undefined : no turn counter is built and `anomalia` is tied low.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   iniciar          start pulse (only honoured in ESPERA)
//   head/left        wall ahead / wall on the left
//   under            robot stands on a black (start/end) cell
//   barrier, classe  debris ahead and its class (0 treated as light)
//   step_mode, step  step execution mode and its advance pulse
//   avancar, girar   one-cycle motion pulses (forward / rotate left)
//   recolher_entulho held high while debris is being removed
//   ocupado          high outside ESPERA, FIM and ERRO
//   fim, anomalia    sticky end-of-pipe / watchdog flags
// -----------------------------------------------------------------------------
module robo_navegador_param #(
    parameter int REM_LEVE   = 3,
    parameter int REM_MEDIO  = 6,
    parameter int REM_PESADO = 9,
    parameter int CNT_W      = 4,
    parameter int WDOG_GIROS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       head,
    input  logic       left,
    input  logic       under,
    input  logic       barrier,
    input  logic [1:0] classe,
    input  logic       step_mode,
    input  logic       step,
    output logic       avancar,
    output logic       girar,
    output logic       recolher_entulho,
    output logic       ocupado,
    output logic       fim,
    output logic       anomalia
);

    typedef enum logic [2:0] {
        ESPERA = 3'd0,
        DECIDE = 3'd1,
        REMOVE = 3'd2,
        FIM    = 3'd3,
        ERRO   = 3'd4
    } estado_t;

    estado_t          estado_r, estado_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             ultimo_giro_r, ultimo_giro_s;
    logic             saiu_inicio_r, saiu_inicio_s;
    logic             avancar_r, avancar_s;
    logic             girar_r, girar_s;
    logic             recolher_r, recolher_s;
    logic             ocupado_r, ocupado_s;
    logic             fim_r, fim_s;
    logic             dispara_s;
    logic             wdog_trip_s;

    // Removal duration for a debris class; class 0 is handled as light debris.
    function automatic logic [CNT_W-1:0] rem_ciclos(input logic [1:0] cls);
        logic [CNT_W-1:0] n;
        case (cls)
            2'd2:    n = CNT_W'(REM_MEDIO);
            2'd3:    n = CNT_W'(REM_PESADO);
            default: n = CNT_W'(REM_LEVE);
        endcase
        return n;
    endfunction

    assign dispara_s = ~step_mode | step;

`ifdef ROBO_WATCHDOG_EN
    localparam int WG_W = $clog2(WDOG_GIROS + 1);

    logic [WG_W-1:0] giros_r, giros_s;
    logic            anomalia_r;

    assign wdog_trip_s = (giros_r == WG_W'(WDOG_GIROS));
    assign anomalia    = anomalia_r;

    // Consecutive-turn counter: any advance or removal breaks the streak.
    always_comb begin
        giros_s = giros_r;
        if (avancar_s || (estado_s == REMOVE)) begin
            giros_s = '0;
        end else if (girar_s && !wdog_trip_s) begin
            giros_s = giros_r + WG_W'(1);
        end else begin
            giros_s = giros_r;
        end
    end

    // Watchdog registers; anomalia rises together with the entry into ERRO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            giros_r    <= '0;
            anomalia_r <= 1'b0;
        end else begin
            giros_r    <= giros_s;
            anomalia_r <= anomalia_r | (estado_s == ERRO);
        end
    end
`else
    assign wdog_trip_s = 1'b0;
    assign anomalia    = 1'b0;
`endif

    // Next-state and next-output logic of the navigation FSM.
    always_comb begin
        estado_s      = estado_r;
        cnt_s         = cnt_r;
        ultimo_giro_s = ultimo_giro_r;
        saiu_inicio_s = saiu_inicio_r;
        avancar_s     = 1'b0;
        girar_s       = 1'b0;
        recolher_s    = 1'b0;

        case (estado_r)
            ESPERA: begin
                if (iniciar) begin
                    estado_s = DECIDE;
                end else begin
                    estado_s = ESPERA;
                end
            end
            DECIDE: begin
                // The watchdog trips on the cycle after the last counted turn,
                // independently of step gating.
                if (wdog_trip_s) begin
                    estado_s = ERRO;
                end else if (dispara_s) begin
                    if (under && saiu_inicio_r) begin
                        estado_s = FIM;
                    end else if (barrier) begin
                        cnt_s      = rem_ciclos(classe);
                        recolher_s = 1'b1;
                        estado_s   = REMOVE;
                    end else if (!left && !ultimo_giro_r) begin
                        // ultimo_giro stops a second left turn into the same gap.
                        girar_s       = 1'b1;
                        ultimo_giro_s = 1'b1;
                    end else if (!head) begin
                        avancar_s     = 1'b1;
                        ultimo_giro_s = 1'b0;
                        saiu_inicio_s = 1'b1;
                    end else begin
                        girar_s       = 1'b1;
                        ultimo_giro_s = 1'b1;
                    end
                end else begin
                    estado_s = DECIDE;
                end
            end
            REMOVE: begin
                // Counter was loaded with N while recolher rose; leaving at
                // count 1 keeps recolher high for exactly N cycles.
                if (cnt_r <= CNT_W'(1)) begin
                    cnt_s      = '0;
                    recolher_s = 1'b0;
                    estado_s   = DECIDE;
                end else begin
                    cnt_s      = cnt_r - CNT_W'(1);
                    recolher_s = 1'b1;
                end
            end
            FIM: begin
                estado_s = FIM;
            end
            ERRO: begin
                estado_s = ERRO;
            end
            default: begin
                estado_s = ESPERA;
                cnt_s    = '0;
            end
        endcase

        ocupado_s = (estado_s == DECIDE) || (estado_s == REMOVE);
        fim_s     = fim_r | (estado_s == FIM);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_r      <= ESPERA;
            cnt_r         <= '0;
            ultimo_giro_r <= 1'b0;
            saiu_inicio_r <= 1'b0;
            avancar_r     <= 1'b0;
            girar_r       <= 1'b0;
            recolher_r    <= 1'b0;
            ocupado_r     <= 1'b0;
            fim_r         <= 1'b0;
        end else begin
            estado_r      <= estado_s;
            cnt_r         <= cnt_s;
            ultimo_giro_r <= ultimo_giro_s;
            saiu_inicio_r <= saiu_inicio_s;
            avancar_r     <= avancar_s;
            girar_r       <= girar_s;
            recolher_r    <= recolher_s;
            ocupado_r     <= ocupado_s;
            fim_r         <= fim_s;
        end
    end

    assign avancar          = avancar_r;
    assign girar            = girar_r;
    assign recolher_entulho = recolher_r;
    assign ocupado          = ocupado_r;
    assign fim              = fim_r;

endmodule

// File: doc/robo_navegador_param.md
# robo_navegador_param

Parametrised successor of the robot navigation controller. Drives the robot through the pipe map using a left-hand wall-following rule. It removes debris internally with per-class removal timers, supports a run/step execution mode, and flags the end-of-pipe cell. It sits between the sensor front end (head, left, under, barrier plus debris class) and the motion actuators, and replaces the fixed controller that relied on the bench to time debris removal.

## Interface
- REM_LEVE, 3: cycles `recolher_entulho` is held for light debris (class 1)
- REM_MEDIO, 6: cycles held for medium debris (class 2)
- REM_PESADO, 9: cycles held for heavy debris (class 3)
- CNT_W, 4: removal counter width; each REM_* must be in 1..2^CNT_W-1
- WDOG_GIROS, 4: consecutive turns without an advance that trip the watchdog (ROBO_WATCHDOG_EN only)

Ports:
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- iniciar  in  1  one-cycle start pulse; leaves ESPERA
- head  in  1  wall directly ahead
- left  in  1  wall on the left
- under  in  1  robot is on a black (pipe start/end) cell
- barrier  in  1  debris directly ahead
- classe  in  2  debris class: 1 = light, 2 = medium, 3 = heavy; 0 is treated as 1
- step_mode  in  1  1 = step mode, 0 = continuous
- step  in  1  one-cycle advance pulse, used only in step mode
- avancar  out  1  one-cycle pulse: move one cell forward
- girar  out  1  one-cycle pulse: rotate 90° left
- recolher_entulho  out  1  held high during removal
- ocupado  out  1  high in every state except ESPERA, FIM, ERRO
- fim  out  1  end cell reached; sticky until reset
- anomalia  out  1  watchdog trip; sticky until reset

## Operation
- States: ESPERA, DECIDE, REMOVE, FIM, ERRO.
- Reset asserted: state = ESPERA, all outputs 0, counter 0, `ultimo_giro` = 0, `saiu_inicio` = 0, turn count = 0.
- ESPERA: when `iniciar` = 1, go to DECIDE.
- DECIDE fires only when `step_mode` = 0, or when `step_mode` = 1 and `step` = 1. Otherwise it holds and all pulses stay 0. When it fires, the first true rule applies:
  1. `under` = 1 and `saiu_inicio` = 1: go to FIM, set `fim`.
  2. `barrier` = 1: load the counter with REM_* for `classe`, raise `recolher_entulho`, go to REMOVE.
  3. `left` = 0 and `ultimo_giro` = 0: pulse `girar`, set `ultimo_giro`.
  4. `head` = 0: pulse `avancar`, clear `ultimo_giro`, set `saiu_inicio`.
  5. Otherwise: pulse `girar`, set `ultimo_giro`.
- REMOVE: decrement the counter every cycle regardless of `step_mode`. When the counter reaches 1, drop `recolher_entulho` and return to DECIDE. Sensor changes are ignored during REMOVE.
- FIM and ERRO are terminal; only reset leaves them.
- At most one of `avancar`, `girar`, `recolher_entulho` is high in any cycle.

## Timing
- All outputs are registered. Sensors sampled at edge k produce a command visible from edge k to edge k+1.
- `avancar` and `girar` last exactly one cycle per firing. In continuous mode, consecutive DECIDE firings issue one command per cycle.
- Removal: `recolher_entulho` is high for exactly REM_* cycles. The earliest next command is the cycle after it falls.
- `iniciar` is ignored outside ESPERA.
- `step` arriving during REMOVE is discarded, not queued.
- Changing `step_mode` mid-run takes effect at the next DECIDE evaluation.
- Reset asserted mid-removal: `recolher_entulho` drops asynchronously and the counter clears.
- `fim` and `anomalia` rise in the same cycle the state enters FIM or ERRO.

## Configuration
- ROBO_WATCHDOG_EN defined:
  - Count consecutive `girar` pulses with no intervening `avancar` or removal.
  - When the count reaches WDOG_GIROS, the next cycle enters ERRO, sets `anomalia`, and gates all actuator pulses.
- ROBO_WATCHDOG_EN undefined:
  - No counter is built; `anomalia` is tied to 0 and ERRO is unreachable.

## Test plan
- Reset low mid-run, then high, then `iniciar`. Expect all outputs 0 while reset is low, and `ocupado` = 1 the cycle after `iniciar`.
- Continuous mode, `head` = 0, `left` = 1, `barrier` = 0, `under` = 0. Expect `avancar` pulses on every cycle and `girar` = 0.
- `barrier` = 1 for each of `classe` = 1, 2, 3 with defaults. Expect `recolher_entulho` high for exactly 3, 6, 9 cycles, then a command on the next cycle.
- `left` = 0 and `head` = 0. Expect `girar`, then `avancar` on the following cycle (`ultimo_giro` blocks a second left turn).
- Step mode with `step` pulses at cycles 5 and 12. Expect exactly two commands, at cycles 6 and 13.
- With ROBO_WATCHDOG_EN and `head` = `left` = 1 constant: expect 4 `girar` pulses, then `anomalia` = 1 with no further pulses. Separately, `under` = 1 after one `avancar`: expect `fim` = 1 and `ocupado` = 0.
